// File: rtl/score_pkg.sv
// Shared types and BCD helper for the score tracker.
package score_pkg;

  typedef enum logic [1:0] {PLAY, ADD, DONE} score_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } score_t;

  // Two-digit BCD add of a 0..9 addend; saturates at 99 instead of wrapping.
  function automatic score_t bcd_add(input score_t s, input logic [3:0] addend);
    score_t     res;
    logic [4:0] ones_sum;
    logic [4:0] tens_sum;
    logic       carry;
    ones_sum = {1'b0, s.ones} + {1'b0, addend};
    carry    = (ones_sum > 5'd9);
    if (carry) ones_sum = ones_sum - 5'd10;
    tens_sum = {1'b0, s.tens} + {4'd0, carry};
    if (tens_sum > 5'd9) begin
      res.tens = BCD_MAX;
      res.ones = BCD_MAX;
    end else begin
      res.tens = tens_sum[3:0];
      res.ones = ones_sum[3:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge PRESS pulse.
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic R,
  input  logic BTN,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced input disagrees with the accepted level,
  // so any bounce back to the accepted level restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

endmodule

// File: rtl/score_tracker.sv
// Debounced submit -> per-round BCD score accumulation, round counting and game-over flag.
module score_tracker
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_ROUNDS      = 10,
  parameter int MAX_PER_ROUND   = 5
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       BTN,
  input  logic [3:0] NUM_CORRECT,
  output logic [3:0] SCORE_TENS,
  output logic [3:0] SCORE_ONES,
  output logic [3:0] ROUND,
  output logic       SCORE_VALID,
  output logic       GAME_OVER
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] CLAMP      = 4'(MAX_PER_ROUND);

  logic btn_level, btn_press, press;

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .CLK   (CLK),
    .R     (R),
    .BTN   (BTN),
    .LEVEL (btn_level),
    .PRESS (btn_press)
  );

  // The pulse only ever fires alongside a high accepted level; qualifying keeps the pair coherent.
  assign press = btn_press & btn_level;

  score_state_t state_q, state_d;
  logic [3:0]   addend_q, addend_d;
  score_t       score_q, score_d, score_sum;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         over_q, over_d;

  assign score_sum = bcd_add(score_q, addend_q);

  always_comb begin
    state_d  = state_q;
    addend_d = addend_q;
    score_d  = score_q;
    round_d  = round_q;
    valid_d  = 1'b0;
    over_d   = over_q;
    case (state_q)
      PLAY: begin
        if (press) begin
          addend_d = (NUM_CORRECT > CLAMP) ? CLAMP : NUM_CORRECT;
          state_d  = ADD;
        end
      end
      ADD: begin
        score_d = score_sum;
        valid_d = 1'b1;
        if (round_q == LAST_ROUND) begin
          over_d  = 1'b1;
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = PLAY;
        end
      end
      DONE: begin
        if (press) begin
          score_d = '0;
          round_d = 4'd1;
          over_d  = 1'b0;
          state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q  <= PLAY;
      addend_q <= '0;
      score_q  <= '0;
      round_q  <= 4'd1;
      valid_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addend_q <= addend_d;
      score_q  <= score_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      over_q   <= over_d;
    end
  end

  assign SCORE_TENS  = score_q.tens;
  assign SCORE_ONES  = score_q.ones;
  assign ROUND       = round_q;
  assign SCORE_VALID = valid_q;
  assign GAME_OVER   = over_q;

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench: stimulus queues expected score updates, monitors pop them on SCORE_VALID.
module tb_score_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut A: short game; dut B: long game with 9-per-round clamp for saturation
  logic       r_a, btn_a, valid_a, go_a;
  logic [3:0] nc_a, tens_a, ones_a, round_a;
  logic       r_b, btn_b, valid_b, go_b;
  logic [3:0] nc_b, tens_b, ones_b, round_b;

  score_tracker #(.DEBOUNCE_CYCLES(4), .NUM_ROUNDS(3), .MAX_PER_ROUND(5)) dut_a (
    .CLK(clk), .R(r_a), .BTN(btn_a), .NUM_CORRECT(nc_a),
    .SCORE_TENS(tens_a), .SCORE_ONES(ones_a), .ROUND(round_a),
    .SCORE_VALID(valid_a), .GAME_OVER(go_a)
  );

  score_tracker #(.DEBOUNCE_CYCLES(4), .NUM_ROUNDS(15), .MAX_PER_ROUND(9)) dut_b (
    .CLK(clk), .R(r_b), .BTN(btn_b), .NUM_CORRECT(nc_b),
    .SCORE_TENS(tens_b), .SCORE_ONES(ones_b), .ROUND(round_b),
    .SCORE_VALID(valid_b), .GAME_OVER(go_b)
  );

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] round;
    logic       go;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 32'(valid_a), 32'd0);
      else begin
        ea = q_a.pop_front();
        check("a_score_round_go", 32'({tens_a, ones_a, round_a, go_a}),
              32'({ea.tens, ea.ones, ea.round, ea.go}));
        check("a_valid_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 32'(valid_b), 32'd0);
      else begin
        eb = q_b.pop_front();
        check("b_score_round_go", 32'({tens_b, ones_b, round_b, go_b}),
              32'({eb.tens, eb.ones, eb.round, eb.go}));
        check("b_valid_cycle", 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  // Clean press: BTN rises after edge c0, SCORE_VALID expected at edge c0+8
  // (2 sync + 4 debounce edges -> PRESS, then latch edge, then ADD edge).
  task automatic press(input bit sel, input logic [3:0] nc, input bit exp_v,
                       input logic [3:0] t, input logic [3:0] o,
                       input logic [3:0] rd, input logic go);
    @(negedge clk);
    if (sel == 1'b0) begin
      nc_a = nc; btn_a = 1'b1;
      if (exp_v) q_a.push_back('{tens:t, ones:o, round:rd, go:go, cyc:cyc + 8});
    end else begin
      nc_b = nc; btn_b = 1'b1;
      if (exp_v) q_b.push_back('{tens:t, ones:o, round:rd, go:go, cyc:cyc + 8});
    end
    repeat (12) @(negedge clk);
    if (sel == 1'b0) begin btn_a = 1'b0; nc_a = 4'hF; end
    else             begin btn_b = 1'b0; nc_b = 4'hF; end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    r_a = 1'b0; btn_a = 1'b0; nc_a = 4'd0;
    r_b = 1'b0; btn_b = 1'b0; nc_b = 4'd0;
    repeat (3) @(negedge clk);
    r_a = 1'b1; r_b = 1'b1;
    @(negedge clk);
    check("a_reset", 32'({tens_a, ones_a, round_a, valid_a, go_a}), 32'({4'd0, 4'd0, 4'd1, 1'b0, 1'b0}));
    check("b_reset", 32'({tens_b, ones_b, round_b, valid_b, go_b}), 32'({4'd0, 4'd0, 4'd1, 1'b0, 1'b0}));

    // bounce: 2-cycle toggles never satisfy the 4-cycle window; final settle gives one press
    nc_a = 4'd2;
    for (int i = 0; i < 5; i++) begin
      btn_a = 1'b1; repeat (2) @(negedge clk);
      btn_a = 1'b0; repeat (2) @(negedge clk);
    end
    btn_a = 1'b1;
    q_a.push_back('{tens:4'd0, ones:4'd2, round:4'd2, go:1'b0, cyc:cyc + 8});
    repeat (12) @(negedge clk);
    btn_a = 1'b0;
    repeat (10) @(negedge clk);
    check("a_bounce_drain", 32'(q_a.size()), 32'd0);

    @(negedge clk); r_a = 1'b0;
    @(negedge clk); r_a = 1'b1;
    @(negedge clk);
    check("a_reset2", 32'({tens_a, ones_a, round_a, go_a}), 32'({4'd0, 4'd0, 4'd1, 1'b0}));

    // accumulate, clamp, game over, restart
    press(1'b0, 4'd5, 1'b1, 4'd0, 4'd5, 4'd2, 1'b0);
    press(1'b0, 4'd7, 1'b1, 4'd1, 4'd0, 4'd3, 1'b0);
    press(1'b0, 4'd3, 1'b1, 4'd1, 4'd3, 4'd3, 1'b1);
    check("a_over_held", 32'({tens_a, ones_a, round_a, go_a}), 32'({4'd1, 4'd3, 4'd3, 1'b1}));
    press(1'b0, 4'd2, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    check("a_restart", 32'({tens_a, ones_a, round_a, valid_a, go_a}), 32'({4'd0, 4'd0, 4'd1, 1'b0, 1'b0}));
    check("a_queue_empty", 32'(q_a.size()), 32'd0);

    // reset asserted in the ADD cycle (after edge c0+7): pending addend must vanish
    @(negedge clk);
    nc_a = 4'd4; btn_a = 1'b1;
    repeat (7) @(negedge clk);
    r_a = 1'b0; btn_a = 1'b0;
    repeat (2) @(negedge clk);
    check("a_in_reset", 32'({tens_a, ones_a, round_a, valid_a, go_a}), 32'({4'd0, 4'd0, 4'd1, 1'b0, 1'b0}));
    r_a = 1'b1;
    repeat (15) @(negedge clk);
    check("a_after_midop_reset", 32'({tens_a, ones_a, round_a, valid_a, go_a}), 32'({4'd0, 4'd0, 4'd1, 1'b0, 1'b0}));

    // saturation: 10 x 9 = 90, +5 = 95, +9 saturates to 99, +9 stays 99
    for (int k = 1; k <= 10; k++)
      press(1'b1, 4'd9, 1'b1, 4'(k - 1), 4'(10 - k), 4'(k + 1), 1'b0);
    press(1'b1, 4'd5, 1'b1, 4'd9, 4'd5, 4'd12, 1'b0);
    press(1'b1, 4'd9, 1'b1, 4'd9, 4'd9, 4'd13, 1'b0);
    press(1'b1, 4'd9, 1'b1, 4'd9, 4'd9, 4'd14, 1'b0);
    check("b_final", 32'({tens_b, ones_b, round_b, go_b}), 32'({4'd9, 4'd9, 4'd14, 1'b0}));
    check("b_queue_empty", 32'(q_b.size()), 32'd0);
    check("a_queue_final", 32'(q_a.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
